// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the ID/EX issue slice.
//   - MIPS-style opcode and funct field values accepted by the decoder
//   - ALU control codes driven onto ex_ctl
//   - dec_t: decoded control bundle handed from issue_decoder to id_ex_issue
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [2:0] {
    CTL_AND = 3'b000,
    CTL_OR  = 3'b001,
    CTL_ADD = 3'b010,
    CTL_SUB = 3'b110,
    CTL_SLT = 3'b111
  } alu_ctl_e;

  typedef struct packed {
    logic     illegal;   // unknown opcode/funct: issue a bubble instead
    alu_ctl_e ctl;
    logic     b_imm;     // operand b is the sign-extended immediate
    logic     uses_rt;   // rt is a real source (hazard / forwarding relevant)
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     memtoreg;
  } dec_t;

endpackage

// File: rtl/id_ex_issue_if.sv
// id_ex_issue_if: ID/EX pipeline register contents as seen by the EX stage.
//   master : id_ex_issue (drives the registered operands/controls)
//   slave  : EX-stage ALU+shifter and later-stage control
// Signals: ex_valid, ex_a, ex_b, ex_store_data, ex_opcode, ex_immed, ex_ctl,
//          ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
interface id_ex_issue_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_store_data;
  logic [5:0]        ex_opcode;
  logic [15:0]       ex_immed;
  logic [2:0]        ex_ctl;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_memtoreg;

  modport master (
    output ex_valid, ex_a, ex_b, ex_store_data, ex_opcode, ex_immed, ex_ctl,
           ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );

  modport slave (
    input  ex_valid, ex_a, ex_b, ex_store_data, ex_opcode, ex_immed, ex_ctl,
           ex_dst, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg
  );
endinterface

// File: rtl/issue_decoder.sv
// issue_decoder: purely combinational instruction decode for id_ex_issue.
//   instr : ID-stage instruction word
//   dec   : ALU control, operand-b select, rt usage, stage controls, illegal
//   dst   : destination register; 0 whenever the instruction writes nothing
// Writes to $0 are dropped here so downstream hazard/forward logic only ever
// sees real producers.
module issue_decoder
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec,
  output logic [4:0]  dst
);

  logic [5:0] op, fn;
  logic [4:0] rt, rd;
  // rs and shamt are consumed by the top / shifter, not by decode
  logic       unused_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign unused_bits = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec = '0;
    dst = '0;
    case (op)
      OP_RTYPE: begin
        dec.uses_rt  = 1'b1;
        dec.regwrite = 1'b1;
        dst          = rd;
        case (fn)
          FN_ADD:  dec.ctl = CTL_ADD;
          FN_SUB:  dec.ctl = CTL_SUB;
          FN_AND:  dec.ctl = CTL_AND;
          FN_OR:   dec.ctl = CTL_OR;
          FN_SLT:  dec.ctl = CTL_SLT;
          FN_SRL:  dec.ctl = CTL_ADD;  // shifter takes shamt from ex_immed
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        dec.ctl = CTL_ADD; dec.b_imm = 1'b1; dec.regwrite = 1'b1; dst = rt;
      end
      OP_SLTI: begin
        dec.ctl = CTL_SLT; dec.b_imm = 1'b1; dec.regwrite = 1'b1; dst = rt;
      end
      OP_LW: begin
        dec.ctl = CTL_ADD; dec.b_imm = 1'b1; dec.regwrite = 1'b1;
        dec.memread = 1'b1; dec.memtoreg = 1'b1; dst = rt;
      end
      OP_SW: begin
        dec.ctl = CTL_ADD; dec.b_imm = 1'b1; dec.memwrite = 1'b1;
        dec.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.ctl = CTL_SUB; dec.uses_rt = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // $0 is never a destination
    if (dst == 5'd0) dec.regwrite = 1'b0;
    if (!dec.regwrite) dst = '0;
  end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue: decodes the ID instruction, selects operands, detects hazards
// and loads the ID/EX pipeline register feeding the EX-stage ALU+shifter.
//   clk, rst        : clock, synchronous active-high reset
//   id_valid/instr  : IF/ID contents
//   rs_data/rt_data : register file read ports (instr[25:21] / instr[20:16])
//   ex_alu_result   : result of the instruction now in ID/EX
//   mem_* / wb_*    : later-stage producers
//   flush           : squash the instruction entering ID/EX
//   stall           : combinational hold for PC and IF/ID
//   exif            : ID/EX register outputs (id_ex_issue_if.master)
// Build option: FORWARDING_EN
//   defined   - EX > MEM > WB > regfile forwarding, stall only on load-use
//   undefined - WB write-through only; stall while ID/EX or MEM will write a
//               source register
module id_ex_issue
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  id_ex_issue_if.master     exif
);

  dec_t              dec;
  logic [4:0]        dst;
  logic [REG_AW-1:0] rs_a, rt_a, ex_dst_q;
  logic [DATA_W-1:0] rs_v, rt_v, imm_x;
  logic              ex_hit, hz, live, issue;

  issue_decoder u_dec (
    .instr (id_instr),
    .dec   (dec),
    .dst   (dst)
  );

  assign rs_a     = REG_AW'(id_instr[25:21]);
  assign rt_a     = REG_AW'(id_instr[20:16]);
  assign ex_dst_q = exif.ex_dst;
  assign imm_x    = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

  // ID/EX destination is one of this instruction's sources
  assign ex_hit = (ex_dst_q != '0) &&
                  ((ex_dst_q == rs_a) || (dec.uses_rt && (ex_dst_q == rt_a)));

`ifdef FORWARDING_EN
  // A load in ID/EX has no data yet, so it cannot be an EX forward source.
  logic ex_fwd_ok;
  assign ex_fwd_ok = exif.ex_regwrite && !exif.ex_memread;

  function automatic logic [DATA_W-1:0] src(input logic [REG_AW-1:0] r,
                                            input logic [DATA_W-1:0] rf);
    if (r == '0)                               return '0;
    if (ex_fwd_ok && (ex_dst_q == r))          return ex_alu_result;
    if (mem_regwrite && (mem_dst == r))        return mem_data;
    if (wb_regwrite && (wb_dst == r))          return wb_data;
    return rf;
  endfunction

  assign hz = exif.ex_memread && ex_hit;
`else
  logic mem_hit;
  logic unused_fwd;
  assign unused_fwd = ^{ex_alu_result, mem_data};

  function automatic logic [DATA_W-1:0] src(input logic [REG_AW-1:0] r,
                                            input logic [DATA_W-1:0] rf);
    if (r == '0)                               return '0;
    if (wb_regwrite && (wb_dst == r))          return wb_data;
    return rf;
  endfunction

  assign mem_hit = mem_regwrite && (mem_dst != '0) &&
                   ((mem_dst == rs_a) || (dec.uses_rt && (mem_dst == rt_a)));
  assign hz = (exif.ex_regwrite && ex_hit) || mem_hit;
`endif

  always_comb begin
    rs_v = src(rs_a, rs_data);
    rt_v = src(rt_a, rt_data);
  end

  // Illegal instructions become bubbles anyway, so they never stall.
  assign live  = id_valid && !dec.illegal;
  assign stall = !rst && !flush && live && hz;
  assign issue = live && !flush && !hz;

  // A bubble is the all-zero register, identical to the reset image.
  always_ff @(posedge clk) begin
    if (rst || !issue) begin
      exif.ex_valid      <= 1'b0;
      exif.ex_a          <= '0;
      exif.ex_b          <= '0;
      exif.ex_store_data <= '0;
      exif.ex_opcode     <= '0;
      exif.ex_immed      <= '0;
      exif.ex_ctl        <= '0;
      exif.ex_dst        <= '0;
      exif.ex_regwrite   <= 1'b0;
      exif.ex_memread    <= 1'b0;
      exif.ex_memwrite   <= 1'b0;
      exif.ex_memtoreg   <= 1'b0;
    end else begin
      exif.ex_valid      <= 1'b1;
      exif.ex_a          <= rs_v;
      exif.ex_b          <= dec.b_imm ? imm_x : rt_v;
      exif.ex_store_data <= dec.memwrite ? rt_v : '0;
      exif.ex_opcode     <= id_instr[31:26];
      exif.ex_immed      <= id_instr[15:0];
      exif.ex_ctl        <= dec.ctl;
      exif.ex_dst        <= REG_AW'(dst);
      exif.ex_regwrite   <= dec.regwrite;
      exif.ex_memread    <= dec.memread;
      exif.ex_memwrite   <= dec.memwrite;
      exif.ex_memtoreg   <= dec.memtoreg;
    end
  end

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed plan cases plus randomized traffic, checked against
// a rule-level model of the ID/EX register (expected contents and stall).
module tb_id_ex_issue;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, id_valid, flush, stall;
  logic [31:0]   id_instr;
  logic [DW-1:0] rs_data, rt_data, ex_alu_result, mem_data, wb_data;
  logic          mem_regwrite, wb_regwrite;
  logic [AW-1:0] mem_dst, wb_dst;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_issue_if #(.DATA_W(DW), .REG_AW(AW)) exif ();

  id_ex_issue #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .ex_alu_result (ex_alu_result),
    .mem_regwrite  (mem_regwrite),
    .mem_dst       (mem_dst),
    .mem_data      (mem_data),
    .wb_regwrite   (wb_regwrite),
    .wb_dst        (wb_dst),
    .wb_data       (wb_data),
    .flush         (flush),
    .stall         (stall),
    .exif          (exif)
  );

  // expected ID/EX contents
  typedef struct packed {
    logic        valid;
    logic [31:0] a, b, sd;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [2:0]  ctl;
    logic [4:0]  dst;
    logic        rw, mr, mw, mtr;
  } ex_t;

  ex_t m = '0;
  bit  last_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] R(input logic [4:0] rd, rs, rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] I(input logic [5:0] op, input logic [4:0] rs, rt,
                                    input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  // Value an instruction in ID must see for register r: the youngest
  // in-flight producer that can supply it, else the register file.
  function automatic logic [31:0] val(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
`ifdef FORWARDING_EN
    if (m.rw && !m.mr && m.dst == r) return ex_alu_result;
    if (mem_regwrite && mem_dst == r) return mem_data;
`endif
    if (wb_regwrite && wb_dst == r) return wb_data;
    return rf;
  endfunction

  // Register r cannot be supplied yet by any legal path.
  function automatic bit blocked(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
`ifdef FORWARDING_EN
    return m.mr && (m.dst == r);
`else
    return (m.rw && m.dst == r) || (mem_regwrite && mem_dst == r);
`endif
  endfunction

  task automatic model(output bit es, output ex_t nx);
    bit          legal, wr, ld, st, immb, use_rt;
    logic [2:0]  ctl;
    logic [4:0]  d, rs, rt;
    logic [5:0]  op, fn;
    op = id_instr[31:26]; fn = id_instr[5:0];
    rs = id_instr[25:21]; rt = id_instr[20:16];
    legal = 1; wr = 0; ld = 0; st = 0; immb = 1; use_rt = 0; d = rt; ctl = 3'd2;
    if (op == 6'h00) begin
      immb = 0; use_rt = 1; wr = 1; d = id_instr[15:11];
      case (fn)
        6'h20: ctl = 3'd2;
        6'h22: ctl = 3'd6;
        6'h24: ctl = 3'd0;
        6'h25: ctl = 3'd1;
        6'h2a: ctl = 3'd7;
        6'h02: ctl = 3'd2;
        default: legal = 0;
      endcase
    end else begin
      case (op)
        6'h08: wr = 1;
        6'h0a: begin wr = 1; ctl = 3'd7; end
        6'h23: begin wr = 1; ld = 1; end
        6'h2b: begin st = 1; use_rt = 1; end
        6'h04: begin immb = 0; use_rt = 1; ctl = 3'd6; end
        default: legal = 0;
      endcase
    end
    if (d == 5'd0) wr = 0;
    es = !rst && !flush && id_valid && legal && (blocked(rs) || (use_rt && blocked(rt)));
    nx = '0;
    if (!rst && !flush && id_valid && legal && !(blocked(rs) || (use_rt && blocked(rt)))) begin
      nx.valid = 1;
      nx.a     = val(rs, rs_data);
      nx.b     = immb ? {{16{id_instr[15]}}, id_instr[15:0]} : val(rt, rt_data);
      nx.sd    = st ? val(rt, rt_data) : 32'd0;
      nx.op    = op;
      nx.imm   = id_instr[15:0];
      nx.ctl   = ctl;
      nx.dst   = wr ? d : 5'd0;
      nx.rw    = wr;
      nx.mr    = ld;
      nx.mw    = st;
      nx.mtr   = ld;
    end
  endtask

  task automatic check_out();
    chk("valid", exif.ex_valid, m.valid);
    chk("a", exif.ex_a, m.a);
    chk("b", exif.ex_b, m.b);
    chk("store_data", exif.ex_store_data, m.sd);
    chk("opcode", exif.ex_opcode, m.op);
    chk("immed", exif.ex_immed, m.imm);
    chk("ctl", exif.ex_ctl, m.ctl);
    chk("dst", exif.ex_dst, m.dst);
    chk("regwrite", exif.ex_regwrite, m.rw);
    chk("memread", exif.ex_memread, m.mr);
    chk("memwrite", exif.ex_memwrite, m.mw);
    chk("memtoreg", exif.ex_memtoreg, m.mtr);
  endtask

  // Inputs are driven at the falling edge; stall is sampled before the rising
  // edge, registered outputs at the following falling edge.
  task automatic cyc(output logic st);
    bit  es;
    ex_t nx;
    #1;
    model(es, nx);
    st = stall;
    chk("stall", stall, es);
    last_stall = es;
    @(posedge clk);
    m = nx;
    @(negedge clk);
    check_out();
  endtask

  task automatic idle();
    rst = 0; flush = 0; id_valid = 0; id_instr = '0;
    rs_data = '0; rt_data = '0; ex_alu_result = '0;
    mem_regwrite = 0; mem_dst = '0; mem_data = '0;
    wb_regwrite = 0; wb_dst = '0; wb_data = '0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    im = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return R(rd, rs, rt, 6'h20);
      1:  return R(rd, rs, rt, 6'h22);
      2:  return R(rd, rs, rt, 6'h24);
      3:  return R(rd, rs, rt, 6'h25);
      4:  return R(rd, rs, rt, 6'h2a);
      5:  return {6'h00, rs, rt, rd, im[10:6], 6'h02};
      6:  return I(6'h08, rs, rt, im);
      7:  return I(6'h0a, rs, rt, im);
      8:  return I(6'h23, rs, rt, im);
      9:  return I(6'h2b, rs, rt, im);
      10: return I(6'h04, rs, rt, im);
      11: return I(6'h3f, rs, rt, im);
      default: return R(rd, rs, rt, 6'h3f);
    endcase
  endfunction

  logic s;

  initial begin
    // reset: bubble, stall low even with a valid instruction presented
    idle(); rst = 1; id_valid = 1; id_instr = R(5'd3, 5'd1, 5'd2, 6'h20);
    @(negedge clk);
    cyc(s); chk("rst_stall", s, 1'b0);
    cyc(s);
    chk("rst_valid", exif.ex_valid, 1'b0);
    chk("rst_a", exif.ex_a, 32'd0);
    chk("rst_regwrite", exif.ex_regwrite, 1'b0);

    // add $3,$1,$2
    idle(); id_valid = 1; id_instr = R(5'd3, 5'd1, 5'd2, 6'h20);
    rs_data = 32'd5; rt_data = 32'd7;
    cyc(s);
    chk("add_a", exif.ex_a, 32'd5);
    chk("add_b", exif.ex_b, 32'd7);
    chk("add_ctl", exif.ex_ctl, 3'b010);
    chk("add_dst", exif.ex_dst, 5'd3);
    chk("add_rw", exif.ex_regwrite, 1'b1);
    chk("add_valid", exif.ex_valid, 1'b1);

`ifdef FORWARDING_EN
    // EX forward beats MEM
    id_instr = R(5'd4, 5'd3, 5'd3, 6'h20); rs_data = 32'd1; rt_data = 32'd1;
    ex_alu_result = 32'd12; mem_regwrite = 1; mem_dst = 5'd3; mem_data = 32'd9;
    cyc(s);
    chk("exfwd_stall", s, 1'b0);
    chk("exfwd_a", exif.ex_a, 32'd12);
    chk("exfwd_b", exif.ex_b, 32'd12);
`else
    // $3 in flight: held until it reaches WB
    id_instr = R(5'd4, 5'd3, 5'd1, 6'h20); rs_data = 32'd1; rt_data = 32'h44;
    cyc(s);
    chk("raw_stall1", s, 1'b1);
    chk("raw_bubble1", exif.ex_valid, 1'b0);
    mem_regwrite = 1; mem_dst = 5'd3; mem_data = 32'd9;
    cyc(s);
    chk("raw_stall2", s, 1'b1);
    chk("raw_bubble2", exif.ex_valid, 1'b0);
    mem_regwrite = 0; wb_regwrite = 1; wb_dst = 5'd3; wb_data = 32'h33;
    cyc(s);
    chk("raw_stall3", s, 1'b0);
    chk("raw_a", exif.ex_a, 32'h33);
    chk("raw_b", exif.ex_b, 32'h44);
`endif

    // lw $5,0($1) ; sub $6,$5,$2
    idle(); cyc(s);
    id_valid = 1; id_instr = I(6'h23, 5'd1, 5'd5, 16'd0); rs_data = 32'h100;
    cyc(s);
    chk("lw_memread", exif.ex_memread, 1'b1);
    id_instr = R(5'd6, 5'd5, 5'd2, 6'h22); rs_data = 32'h11; rt_data = 32'd7;
    cyc(s);
    chk("lu_stall", s, 1'b1);
    chk("lu_bubble", exif.ex_valid, 1'b0);
    mem_regwrite = 1; mem_dst = 5'd5; mem_data = 32'hAB;
`ifndef FORWARDING_EN
    cyc(s);
    chk("lu_stall_mem", s, 1'b1);
    mem_regwrite = 0; wb_regwrite = 1; wb_dst = 5'd5; wb_data = 32'hAB;
`endif
    cyc(s);
    chk("lu_go", s, 1'b0);
    chk("lu_a", exif.ex_a, 32'hAB);
    chk("lu_b", exif.ex_b, 32'd7);
    chk("lu_ctl", exif.ex_ctl, 3'b110);

    // addi $0,$1,-1 then reads of $0
    idle(); cyc(s);
    id_valid = 1; id_instr = I(6'h08, 5'd1, 5'd0, 16'hFFFF); rs_data = 32'd3;
    cyc(s);
    chk("z_b", exif.ex_b, 32'hFFFF_FFFF);
    chk("z_rw", exif.ex_regwrite, 1'b0);
    chk("z_valid", exif.ex_valid, 1'b1);
    id_instr = R(5'd7, 5'd0, 5'd0, 6'h20); rs_data = 32'hDEAD; rt_data = 32'hBEEF;
    ex_alu_result = 32'd1; mem_regwrite = 1; mem_dst = 5'd0; mem_data = 32'd2;
    wb_regwrite = 1; wb_dst = 5'd0; wb_data = 32'd3;
    cyc(s);
    chk("z_stall", s, 1'b0);
    chk("z_a", exif.ex_a, 32'd0);
    chk("z_bb", exif.ex_b, 32'd0);

    // flush against a load-use hazard, then reset mid-stream
    idle(); cyc(s);
    id_valid = 1; id_instr = I(6'h23, 5'd1, 5'd5, 16'd4);
    cyc(s);
    id_instr = R(5'd6, 5'd5, 5'd2, 6'h22); flush = 1;
    cyc(s);
    chk("fl_stall", s, 1'b0);
    chk("fl_bubble", exif.ex_valid, 1'b0);
    flush = 0; id_instr = R(5'd3, 5'd1, 5'd2, 6'h20); rs_data = 32'd5; rt_data = 32'd7;
    cyc(s);
    chk("pre_rst_valid", exif.ex_valid, 1'b1);
    rst = 1; id_instr = R(5'd6, 5'd3, 5'd3, 6'h22);
    cyc(s);
    chk("mrst_stall", s, 1'b0);
    chk("mrst_valid", exif.ex_valid, 1'b0);
    chk("mrst_a", exif.ex_a, 32'd0);
    chk("mrst_dst", exif.ex_dst, 5'd0);

    // randomized traffic; a stalled instruction is held like IF/ID would
    idle(); last_stall = 0;
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      if (!last_stall) begin
        id_valid = ($urandom_range(0, 9) != 0);
        id_instr = rnd_instr();
      end
      rs_data       = $urandom;
      rt_data       = $urandom;
      ex_alu_result = $urandom;
      mem_regwrite  = 1'($urandom_range(0, 1));
      mem_dst       = 5'($urandom_range(0, 3));
      mem_data      = $urandom;
      wb_regwrite   = 1'($urandom_range(0, 1));
      wb_dst        = 5'($urandom_range(0, 3));
      wb_data       = $urandom;
      cyc(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_issue.md
Name: id_ex_issue

Overview:
- Operand/control producer for the EX-stage ALU+shifter block; drives its a, b, opcode, immed, ctl inputs.
- Decodes the ID-stage instruction and selects forwarded operands.
- Detects load-use and RAW hazards, then registers everything into the ID/EX pipeline register.
- Sits between IF/ID register + register file and the EX stage.

Parameters:
- DATA_W, 32: operand/result width.
- REG_AW, 5: register index width.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- id_valid  in  1  IF/ID holds a real instruction
- id_instr  in  32  instruction word
- rs_data  in  DATA_W  regfile read port for instr[25:21]
- rt_data  in  DATA_W  regfile read port for instr[20:16]
- ex_alu_result  in  DATA_W  current EX-stage ALU result (instruction now in ID/EX)
- mem_regwrite  in  1  MEM-stage instruction writes a register
- mem_dst  in  REG_AW  MEM-stage destination
- mem_data  in  DATA_W  MEM-stage result (load data already muxed)
- wb_regwrite  in  1  WB write enable
- wb_dst  in  REG_AW  WB destination
- wb_data  in  DATA_W  WB data
- flush  in  1  squash instruction entering ID/EX (taken branch)
- stall  out  1  combinational; hold PC and IF/ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_a, ex_b  out  DATA_W  ALU operands
- ex_store_data  out  DATA_W  forwarded rt for sw
- ex_opcode  out  6  instr[31:26]
- ex_immed  out  16  instr[15:0]; shifter uses [10:6], funct [5:0]
- ex_ctl  out  3  ALU control
- ex_dst  out  REG_AW  destination register
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  stage controls

Behaviour:
- Reset: every registered output is 0, so ID/EX holds a bubble. stall=0 while rst=1.
- Latency: exactly 1 cycle from ID to ID/EX outputs when not stalled.
- Decode, R-type (opcode 000000):
  - funct 100000 → ctl 010; 100010 → ctl 110; 100100 → ctl 000; 100101 → ctl 001; 101010 → ctl 111; 000010 (srl) → ctl 010.
  - dst=rd, b=rt, regwrite=1.
  - Any other funct is illegal.
- Decode, I-type (b = sign-extended imm):
  - addi 001000 → ctl 010, dst=rt, regwrite=1.
  - slti 001010 → ctl 111, dst=rt, regwrite=1.
  - lw 100011 → ctl 010, memread, memtoreg, regwrite, dst=rt.
  - sw 101011 → ctl 010, memwrite, store_data=rt.
  - beq 000100 → ctl 110, b=rt, no regwrite.
- Illegal opcode or funct loads a bubble.
- dst==0 forces regwrite=0. Register 0 is never forwarded and always reads 0.
- Forward priority per source operand: EX (ID/EX regwrite && !memread && ex_dst match) > MEM > WB > regfile.
- Load-use: ID/EX memread && ex_dst≠0 && ex_dst equals a used source of the ID instruction → stall=1, ID/EX loads a bubble, IF/ID is held.
  - Sources used: rs for all; rt for R-type, beq, sw.
- id_valid=0 → bubble loaded, stall=0.
- flush=1 → bubble loaded, stall forced 0. flush wins over stall.
- rst overrides everything.

Optional Feature:
- FORWARDING_EN defined: the forwarding network above.
- Undefined: no EX/MEM forwarding; WB write-through still applies. stall=1 with bubble whenever a used source matches ID/EX dst (regwrite) or mem_dst (mem_regwrite), nonzero. The instruction is held until the match clears.

Decomposition:
- Package cpu_pkg:
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ)
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SRL)
  - ALU ctl constants (CTL_AND=000, CTL_OR=001, CTL_ADD=010, CTL_SUB=110, CTL_SLT=111)
- One combinational sub-module, issue_decoder: instruction → ctl, immediate select, dst select, controls, uses_rt, illegal.

Test Plan:
- add $3,$1,$2 with rs_data=5, rt_data=7 → next cycle ex_a=5, ex_b=7, ex_ctl=010, ex_dst=3, ex_regwrite=1, ex_valid=1.
- add $4,$3,$3 directly after add $3 with ex_alu_result=12 → ex_a=ex_b=12 (EX forward); with mem_dst=3, mem_data=9 also active, EX still wins.
- lw $5,0($1) then sub $6,$5,$2 → stall=1 for one cycle, bubble (ex_valid=0); next cycle sub issues with mem_data forwarded as ex_a.
- addi $0,$1,-1 (immed 0xFFFF) → ex_b=0xFFFFFFFF, ex_regwrite=0; a later add reading $0 gets 0 regardless of forward inputs.
- flush=1 coincident with a load-use hazard → stall=0, bubble loaded; rst mid-stream → all outputs 0 next edge.
- FORWARDING_EN undefined: add $3 then add $4,$3,$1 → stall held 2 cycles until $3 reaches WB, then issues with wb_data.
